// File: rtl/si_countrate.sv
// si_countrate -- per-channel event counter over contiguous tagtime windows.
//
// Sits directly behind si_tag_converter. Each input beat carries WORD_WIDTH
// lanes of (tagtime, channel, edge). Lanes matching the selected edge mode
// are counted per channel inside a window of WINDOW_LEN ps. When a lane's
// tagtime reaches the window end, the live counts are copied into snapshot
// registers that the host reads over Wishbone.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   s_axis_tvalid       beat valid
//   s_axis_tready       low only during reset; the block never backpressures
//   s_axis_tkeep        per-lane valid mask
//   s_axis_channel      5-bit channel per lane, lane i at [5*i +: 5]
//   s_axis_tagtime      64-bit timestamp per lane (ps), lane i at [64*i +: 64]
//   s_axis_rising_edge  edge flag per lane
//   wb_*                Wishbone slave (8-bit byte address, 32-bit data)
//
// Register map:
//   0x00 CTRL          bit0 enable, bits[2:1] edge mode (00 rise, 01 fall, 1x both)
//   0x04/0x08          WINDOW_LEN low/high word
//   0x0C WINDOWS_DONE  wrapping closure count (read-only)
//   0x10 STATUS        bit0 gap, bit1 saturated; sticky, write 1 to clear
//   0x80 + 4*ch        snapshot count of channel ch
//
// Pipeline: S1 registers the accepted-lane mask and lane data, S2 finds the
// boundary lane against window_end and advances the window, S3 applies the
// per-channel increments and takes snapshots.
// Handshake: s_axis is valid-only in practice; a beat transfers on every
// cycle where tvalid and tready are both high, and tready is high whenever
// reset is not asserted.

module si_countrate #(
    parameter int WORD_WIDTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [WORD_WIDTH-1:0]    s_axis_tkeep,
    input  logic [5*WORD_WIDTH-1:0]  s_axis_channel,
    input  logic [64*WORD_WIDTH-1:0] s_axis_tagtime,
    input  logic [WORD_WIDTH-1:0]    s_axis_rising_edge,
    input  logic [7:0]               wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    output logic [31:0]              wb_dat_o,
    input  logic                     wb_we_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o
);

    localparam int NCH   = 32;
    localparam int PC_W  = $clog2(WORD_WIDTH + 1);
    localparam int SUM_W = CNT_WIDTH + PC_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [63:0] WLEN_RESET = 64'd1_000_000_000;

    // ------------------------------------------------------------------
    // Control registers and Wishbone
    // ------------------------------------------------------------------
    logic        ctrl_en_q;
    logic [1:0]  ctrl_mode_q;
    logic [63:0] wlen_q;
    logic [31:0] wdone_q;
    logic        gap_q;
    logic        sat_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rd_data;
    logic        wb_req;
    logic        wb_wr;
    logic        clr_status;

    logic [CNT_WIDTH-1:0] live_q [NCH];
    logic [CNT_WIDTH-1:0] snap_q [NCH];

    assign s_axis_tready = ~rst;
    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;

    // A request is served only while ack is low, so acks never come back to back.
    assign wb_req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wb_wr      = wb_req & wb_we_i;
    assign clr_status = wb_wr && (wb_adr_i == 8'h10);

    always_comb begin
        rd_data = '0;
        if (wb_adr_i[1:0] == 2'b00) begin
            if (wb_adr_i[7]) begin
                rd_data = 32'(snap_q[wb_adr_i[6:2]]);
            end else begin
                case (wb_adr_i[6:2])
                    5'd0:    rd_data = {29'd0, ctrl_mode_q, ctrl_en_q};
                    5'd1:    rd_data = wlen_q[31:0];
                    5'd2:    rd_data = wlen_q[63:32];
                    5'd3:    rd_data = wdone_q;
                    5'd4:    rd_data = {30'd0, sat_q, gap_q};
                    default: rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= 2'b00;
            wlen_q      <= WLEN_RESET;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            ack_q <= wb_req;
            if (wb_req) begin
                dat_q <= rd_data;
            end
            if (wb_wr) begin
                case (wb_adr_i)
                    8'h00: begin
                        ctrl_en_q   <= wb_dat_i[0];
                        ctrl_mode_q <= wb_dat_i[2:1];
                    end
                    8'h04:   wlen_q[31:0]  <= wb_dat_i;
                    8'h08:   wlen_q[63:32] <= wb_dat_i;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: lane acceptance and beat register
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0]    acc_in;
    logic [WORD_WIDTH-1:0]    s1_acc_q;
    logic [5*WORD_WIDTH-1:0]  s1_ch_q;
    logic [64*WORD_WIDTH-1:0] s1_tag_q;

    always_comb begin
        acc_in = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            acc_in[i] = s_axis_tvalid & s_axis_tkeep[i] & ctrl_en_q &
                        (ctrl_mode_q[1] | (s_axis_rising_edge[i] ^ ctrl_mode_q[0]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_acc_q <= '0;
            s1_ch_q  <= '0;
            s1_tag_q <= '0;
        end else begin
            s1_acc_q <= acc_in;
            s1_ch_q  <= s_axis_channel;
            s1_tag_q <= s_axis_tagtime;
        end
    end

    // ------------------------------------------------------------------
    // S2: boundary detection and window advance
    // ------------------------------------------------------------------
    logic                  started_q;
    logic [63:0]           wend_q;
    logic [WORD_WIDTH-1:0] acc2;
    logic [63:0]           len_eff;
    logic                  first_found;
    logic [63:0]           first_tag;
    logic [63:0]           end_eff;
    logic                  b_found;
    logic [63:0]           b_tag;
    logic [63:0]           wend_d;
    logic                  gap_d;
    logic [WORD_WIDTH-1:0] pre_d;
    logic [WORD_WIDTH-1:0] post_d;

    logic [WORD_WIDTH-1:0]   s2_pre_q;
    logic [WORD_WIDTH-1:0]   s2_post_q;
    logic [5*WORD_WIDTH-1:0] s2_ch_q;
    logic                    s2_close_q;
    logic                    s2_gap_q;

    always_comb begin
        len_eff     = (wlen_q == 64'd0) ? 64'd1 : wlen_q;
        acc2        = ctrl_en_q ? s1_acc_q : '0;
        first_found = 1'b0;
        first_tag   = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (acc2[i] && !first_found) begin
                first_found = 1'b1;
                first_tag   = s1_tag_q[i*64 +: 64];
            end
        end
        // Before the first accepted lane the window opens at that lane.
        end_eff = started_q ? wend_q : (first_tag + len_eff);

        b_found = 1'b0;
        b_tag   = '0;
        pre_d   = acc2;
        post_d  = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (acc2[i] && !b_found && (s1_tag_q[i*64 +: 64] >= end_eff)) begin
                b_found = 1'b1;
                b_tag   = s1_tag_q[i*64 +: 64];
            end
            // Lane b and every accepted lane after it belong to the next window.
            if (b_found) begin
                pre_d[i]  = 1'b0;
                post_d[i] = acc2[i];
            end
        end

        wend_d = end_eff;
        gap_d  = 1'b0;
        if (b_found) begin
            if (b_tag < (end_eff + len_eff)) begin
                wend_d = end_eff + len_eff;
            end else begin
                // Empty windows were skipped: restart the window at lane b.
                wend_d = b_tag + len_eff;
                gap_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !ctrl_en_q) begin
            started_q  <= 1'b0;
            wend_q     <= '0;
            s2_pre_q   <= '0;
            s2_post_q  <= '0;
            s2_ch_q    <= '0;
            s2_close_q <= 1'b0;
            s2_gap_q   <= 1'b0;
        end else begin
            if (first_found) begin
                started_q <= 1'b1;
                wend_q    <= wend_d;
            end
            s2_pre_q   <= pre_d;
            s2_post_q  <= post_d;
            s2_ch_q    <= s1_ch_q;
            s2_close_q <= b_found;
            s2_gap_q   <= gap_d;
        end
    end

    // ------------------------------------------------------------------
    // S3: per-channel increments, snapshots, status
    // ------------------------------------------------------------------
    logic [PC_W-1:0]      pre_cnt  [NCH];
    logic [PC_W-1:0]      post_cnt [NCH];
    logic [SUM_W-1:0]     sum_pre  [NCH];
    logic [SUM_W-1:0]     sum_post [NCH];
    logic [CNT_WIDTH-1:0] live_d   [NCH];
    logic [CNT_WIDTH-1:0] snap_d   [NCH];
    logic                 sat_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [SUM_W-1:0] s);
        return (s >= SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        sat_hit = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            pre_cnt[c]  = '0;
            post_cnt[c] = '0;
            for (int i = 0; i < WORD_WIDTH; i++) begin
                if (s2_ch_q[i*5 +: 5] == 5'(c)) begin
                    if (s2_pre_q[i]) begin
                        pre_cnt[c] = pre_cnt[c] + PC_W'(1);
                    end
                    if (s2_post_q[i]) begin
                        post_cnt[c] = post_cnt[c] + PC_W'(1);
                    end
                end
            end
            sum_pre[c]  = SUM_W'(live_q[c]) + SUM_W'(pre_cnt[c]);
            sum_post[c] = SUM_W'(post_cnt[c]);
            snap_d[c]   = snap_q[c];
            if (s2_close_q) begin
                snap_d[c] = sat_cnt(sum_pre[c]);
                live_d[c] = sat_cnt(sum_post[c]);
            end else begin
                live_d[c] = sat_cnt(sum_pre[c]);
            end
            if (((pre_cnt[c] != '0) && (sum_pre[c] >= SUM_W'(CNT_MAX))) ||
                (s2_close_q && (post_cnt[c] != '0) && (sum_post[c] >= SUM_W'(CNT_MAX)))) begin
                sat_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                live_q[c] <= '0;
                snap_q[c] <= '0;
            end
            wdone_q <= '0;
            gap_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            gap_q <= (gap_q & ~(clr_status & wb_dat_i[0])) |
                     (ctrl_en_q & s2_close_q & s2_gap_q);
            sat_q <= (sat_q & ~(clr_status & wb_dat_i[1])) |
                     (ctrl_en_q & sat_hit);
            if (!ctrl_en_q) begin
                // Live counts are not host-visible, so holding them at zero
                // while disabled is the same as clearing them on arm.
                for (int c = 0; c < NCH; c++) begin
                    live_q[c] <= '0;
                end
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    live_q[c] <= live_d[c];
                    snap_q[c] <= snap_d[c];
                end
                if (s2_close_q) begin
                    wdone_q <= wdone_q + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_si_countrate.sv
// Directed bench for si_countrate built with 4-bit counters so that
// saturation is reachable with a short stimulus.

module tb_si_countrate;

    localparam int WW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [WW-1:0] s_axis_tkeep;
    logic [5*WW-1:0]  s_axis_channel;
    logic [64*WW-1:0] s_axis_tagtime;
    logic [WW-1:0] s_axis_rising_edge;
    logic [7:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_we_i;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic          wb_ack_o;

    int n_cmp = 0;
    int n_mis = 0;

    si_countrate #(.WORD_WIDTH(WW), .CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_channel     (s_axis_channel),
        .s_axis_tagtime     (s_axis_tagtime),
        .s_axis_rising_edge (s_axis_rising_edge),
        .wb_adr_i           (wb_adr_i),
        .wb_dat_i           (wb_dat_i),
        .wb_dat_o           (wb_dat_o),
        .wb_we_i            (wb_we_i),
        .wb_stb_i           (wb_stb_i),
        .wb_cyc_i           (wb_cyc_i),
        .wb_ack_o           (wb_ack_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic wb_xfer(input logic [7:0] adr, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        logic seen;
        seen     = 1'b0;
        rdat     = '0;
        wb_adr_i = adr;
        wb_dat_i = wdat;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) begin
                seen = 1'b1;
                rdat = wb_dat_o;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_mis++;
            $display("FAIL wb_ack_timeout: adr 0x%02h got no ack, expected ack within 8 cycles", adr);
        end
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, wdat, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(adr, 1'b0, 32'd0, d);
        check_eq(tag, d, exp);
    endtask

    // One beat, all lanes on channel ch; lane i carries time ti.
    task automatic send_beat(input logic [3:0] keep, input logic [3:0] rise, input logic [4:0] ch,
                             input logic [63:0] t0, input logic [63:0] t1,
                             input logic [63:0] t2, input logic [63:0] t3);
        s_axis_tvalid      = 1'b1;
        s_axis_tkeep       = keep;
        s_axis_rising_edge = rise;
        s_axis_channel     = {ch, ch, ch, ch};
        s_axis_tagtime     = {t3, t2, t1, t0};
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tkeep  = '0;
    endtask

    task automatic send_one(input logic [4:0] ch, input logic [63:0] t, input logic rise);
        send_beat(4'b0001, {3'b000, rise}, ch, t, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] snap_adr(input int ch);
        return 8'(8'h80 + 4 * ch);
    endfunction

    initial begin
        rst                = 1'b1;
        s_axis_tvalid      = 1'b0;
        s_axis_tkeep       = '0;
        s_axis_channel     = '0;
        s_axis_tagtime     = '0;
        s_axis_rising_edge = '0;
        wb_adr_i           = '0;
        wb_dat_i           = '0;
        wb_we_i            = 1'b0;
        wb_stb_i           = 1'b0;
        wb_cyc_i           = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("tready_in_rst", 32'(s_axis_tready), 32'd0);
        check_eq("ack_in_rst", 32'(wb_ack_o), 32'd0);
        check_eq("dat_in_rst", wb_dat_o, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("tready_after_rst", 32'(s_axis_tready), 32'd1);
        rd_check("rst_ctrl", 8'h00, 32'd0);
        rd_check("rst_wlen_lo", 8'h04, 32'h3B9A_CA00);
        rd_check("rst_wlen_hi", 8'h08, 32'd0);
        rd_check("rst_done", 8'h0C, 32'd0);
        rd_check("rst_status", 8'h10, 32'd0);
        rd_check("rst_snap3", snap_adr(3), 32'd0);
        rd_check("unmapped", 8'h40, 32'd0);

        // Ten ch3 tags in [0,1000), then one at the boundary
        wb_write(8'h04, 32'd1000);
        wb_write(8'h08, 32'd0);
        wb_write(8'h00, 32'd1);
        rd_check("ctrl_rb", 8'h00, 32'd1);
        for (int k = 0; k < 10; k++) begin
            send_one(5'd3, 64'(k * 100), 1'b1);
        end
        send_one(5'd3, 64'd1000, 1'b1);
        idle(6);
        rd_check("t1_snap3", snap_adr(3), 32'd10);
        rd_check("t1_done", 8'h0C, 32'd1);
        rd_check("t1_status", 8'h10, 32'd0);
        // Closing [1000,2000) shows the live count carried over the boundary
        send_one(5'd3, 64'd2000, 1'b1);
        idle(6);
        rd_check("t1_snap3_next", snap_adr(3), 32'd1);
        rd_check("t1_done_next", 8'h0C, 32'd2);

        // Four hits on ch5 in one beat
        send_beat(4'b1111, 4'b1111, 5'd5, 64'd2010, 64'd2020, 64'd2030, 64'd2040);
        send_one(5'd0, 64'd3000, 1'b1);
        idle(6);
        rd_check("t2_snap5", snap_adr(5), 32'd4);
        rd_check("t2_snap3", snap_adr(3), 32'd1);
        rd_check("t2_done", 8'h0C, 32'd3);

        // Re-arm with LEN=100; straddling beat 90,95,100,105 on ch1
        wb_write(8'h00, 32'd0);
        wb_write(8'h04, 32'd100);
        wb_write(8'h00, 32'd1);
        idle(2);
        rd_check("t3_done_disarm", 8'h0C, 32'd3);
        send_one(5'd2, 64'd0, 1'b1);
        send_beat(4'b1111, 4'b1111, 5'd1, 64'd90, 64'd95, 64'd100, 64'd105);
        idle(6);
        rd_check("t3_snap1", snap_adr(1), 32'd2);
        rd_check("t3_snap2", snap_adr(2), 32'd1);
        rd_check("t3_snap0_cleared", snap_adr(0), 32'd0);
        rd_check("t3_snap5_overwritten", snap_adr(5), 32'd0);
        rd_check("t3_done", 8'h0C, 32'd4);
        send_one(5'd9, 64'd200, 1'b1);
        idle(6);
        rd_check("t3_snap1_next", snap_adr(1), 32'd2);
        rd_check("t3_snap2_next", snap_adr(2), 32'd0);
        rd_check("t3_done_next", 8'h0C, 32'd5);
        rd_check("t3_status", 8'h10, 32'd0);

        // Gap: start 0, next tag at 550
        wb_write(8'h00, 32'd0);
        wb_write(8'h00, 32'd1);
        send_one(5'd4, 64'd0, 1'b1);
        send_one(5'd4, 64'd550, 1'b1);
        idle(6);
        rd_check("t4_snap4", snap_adr(4), 32'd1);
        rd_check("t4_done", 8'h0C, 32'd6);
        rd_check("t4_gap", 8'h10, 32'd1);
        wb_write(8'h10, 32'd1);
        rd_check("t4_gap_w1c", 8'h10, 32'd0);
        send_one(5'd4, 64'd640, 1'b1);
        idle(6);
        rd_check("t4_no_close_640", 8'h0C, 32'd6);
        send_one(5'd4, 64'd650, 1'b1);
        idle(6);
        rd_check("t4_snap4_next", snap_adr(4), 32'd2);
        rd_check("t4_done_next", 8'h0C, 32'd7);
        rd_check("t4_status_next", 8'h10, 32'd0);

        // Edge filter on ch7: falling only, then both
        wb_write(8'h00, 32'd0);
        wb_write(8'h00, 32'd3);
        send_beat(4'b1111, 4'b1010, 5'd7, 64'd0, 64'd1, 64'd2, 64'd3);
        send_beat(4'b0001, 4'b1110, 5'd7, 64'd4, 64'd5, 64'd6, 64'd7);
        send_one(5'd0, 64'd100, 1'b0);
        idle(6);
        rd_check("t5_snap7_fall", snap_adr(7), 32'd3);
        rd_check("t5_done_fall", 8'h0C, 32'd8);
        wb_write(8'h00, 32'd5);
        rd_check("t5_ctrl_both", 8'h00, 32'd5);
        send_beat(4'b1111, 4'b1010, 5'd7, 64'd110, 64'd111, 64'd112, 64'd113);
        send_beat(4'b0001, 4'b1110, 5'd7, 64'd114, 64'd115, 64'd116, 64'd117);
        send_one(5'd0, 64'd200, 1'b1);
        idle(6);
        rd_check("t5_snap7_both", snap_adr(7), 32'd5);
        rd_check("t5_done_both", 8'h0C, 32'd9);

        // Saturation: 17 ch0 tags with 4-bit counters
        wb_write(8'h00, 32'd0);
        wb_write(8'h00, 32'd1);
        for (int k = 0; k < 4; k++) begin
            send_beat(4'b1111, 4'b1111, 5'd0, 64'(4 * k), 64'(4 * k + 1),
                      64'(4 * k + 2), 64'(4 * k + 3));
        end
        send_one(5'd0, 64'd16, 1'b1);
        send_one(5'd1, 64'd100, 1'b1);
        idle(6);
        rd_check("t6_snap0_sat", snap_adr(0), 32'd15);
        rd_check("t6_status_sat", 8'h10, 32'd2);
        rd_check("t6_done", 8'h0C, 32'd10);

        // Reset mid-window with beats in flight
        send_one(5'd2, 64'd150, 1'b1);
        send_one(5'd2, 64'd160, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("t6_tready_in_rst", 32'(s_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        rd_check("t6_rst_ctrl", 8'h00, 32'd0);
        rd_check("t6_rst_done", 8'h0C, 32'd0);
        rd_check("t6_rst_status", 8'h10, 32'd0);
        rd_check("t6_rst_snap0", snap_adr(0), 32'd0);
        rd_check("t6_rst_snap7", snap_adr(7), 32'd0);
        rd_check("t6_rst_wlen_lo", 8'h04, 32'h3B9A_CA00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
